// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM encoding,
// bubble word and default reset PC / halt word.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; reset and flush
// both leave a bubble (instr 0, pc_plus4 0, valid 0).
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        i_srst,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (i_srst || i_flush) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (!i_stall) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= i_valid;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, BOOT/RUN/HALTED FSM and
// the IF/ID register. Define FETCH_JUMP_EN to add the J-type jump redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
`ifdef FETCH_JUMP_EN
  input  logic        jump,
  input  logic [25:0] jump_index,
`endif
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic        w_redirect;
  logic        w_halt_fetch;

  logic        w_ifid_flush;
  logic        w_ifid_stall;
  logic [31:0] w_ifid_instr;
  logic [31:0] w_ifid_pc_plus4;
  logic        w_ifid_valid;
  logic        w_halted;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = branch_base + branch_offset;

`ifdef FETCH_JUMP_EN
  logic [31:0] w_jump_target;
  assign w_jump_target = {w_pc_plus4[31:28], jump_index, 2'b00};
  assign w_redirect    = branch_taken | jump;
`else
  assign w_redirect    = branch_taken;
`endif

  // HALT only counts when it actually lands in IF/ID during RUN.
  assign w_halt_fetch = (r_state == RUN) && !flush && !stall &&
                        (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A redirect alongside a HALT fetch means the HALT was wrong-path: stay in RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = RUN;
      RUN:     if (w_halt_fetch && !w_redirect) w_state_next = HALTED;
      HALTED:  if (w_redirect) w_state_next = RUN;
      default: w_state_next = BOOT;
    endcase
  end

  always_comb begin
    w_halted        = 1'b0;
    w_ifid_flush    = flush;
    w_ifid_stall    = stall;
    w_ifid_instr    = imem_data;
    w_ifid_pc_plus4 = w_pc_plus4;
    w_ifid_valid    = 1'b1;
    case (r_state)
      RUN: ;
      HALTED: begin
        w_halted        = 1'b1;
        w_ifid_instr    = NOP_WORD;
        w_ifid_pc_plus4 = 32'h0;
        w_ifid_valid    = 1'b0;
      end
      default: w_ifid_flush = 1'b1;
    endcase
  end

  // Redirects win over stall; BOOT always holds the PC.
  always_comb begin
    w_pc_next = r_pc;
    if (r_state == RUN || r_state == HALTED) begin
      if (branch_taken) begin
        w_pc_next = w_branch_target;
      end
`ifdef FETCH_JUMP_EN
      else if (jump) begin
        w_pc_next = w_jump_target;
      end
`endif
      else if (r_state == RUN && !stall && !w_halt_fetch) begin
        w_pc_next = w_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .i_srst     (reset),
    .i_flush    (w_ifid_flush),
    .i_stall    (w_ifid_stall),
    .i_instr    (w_ifid_instr),
    .i_pc_plus4 (w_ifid_pc_plus4),
    .i_valid    (w_ifid_valid),
    .o_instr    (ifid_instr),
    .o_pc_plus4 (ifid_pc_plus4),
    .o_valid    (ifid_valid)
  );

  assign imem_addr = r_pc;
  assign halted    = w_halted;

endmodule
